// File: rtl/cycle_count_ctrl.sv
// cycle_count_ctrl: run-control sequencer for the performance counters.
//
// A small FSM (IDLE/RUN/PAUSE/DONE) gates a cycle counter and an
// instructions-retired counter. The commands start/stop/clear are levels
// sampled every clock, with priority clear > stop > start. A registered
// read port returns counter values or status with a fixed latency of one
// cycle. The block only observes the retire pulse and never stalls the core.
//
// Optional build macro:
//   CC_LIMIT_EN - when defined, RUN auto-terminates into DONE once
//                 cycle_cnt reaches CYCLE_LIMIT. When undefined, DONE is
//                 unreachable and done is tied low.
//
// Ports:
//   clk       in   system clock, all state on posedge
//   rst       in   asynchronous, active-high reset
//   start     in   begin/resume counting
//   stop      in   pause counting
//   clear     in   zero counters and flags, return to IDLE
//   retire    in   one instruction retired this cycle
//   rd_req    in   read request
//   rd_sel    in   0=cycle_cnt, 1=instret_cnt, 2=status, 3=reserved (reads 0)
//   rd_valid  out  read data valid, one cycle after rd_req
//   rd_data   out  read data (WIDTH bits)
//   running   out  high while state==RUN
//   overflow  out  sticky, set when either counter wraps
//   done      out  one-cycle pulse on entry to DONE
//
// Status word: [1:0]=state, [2]=overflow, [3]=running, upper bits zero.

module cycle_count_ctrl #(
  parameter int WIDTH       = 16,
  parameter int CYCLE_LIMIT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             retire,
  input  logic             rd_req,
  input  logic [1:0]       rd_sel,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             running,
  output logic             overflow,
  output logic             done
);

  // The status word needs 4 bits; a limit below 2 leaves no room to run.
  if (WIDTH < 4) begin : g_bad_width
    $error("cycle_count_ctrl: WIDTH must be at least 4");
  end
  if (CYCLE_LIMIT < 2) begin : g_bad_limit
    $error("cycle_count_ctrl: CYCLE_LIMIT must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cycle_q, cycle_d;
  logic [WIDTH-1:0] instret_q, instret_d;
  logic             ovf_q, ovf_d;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             hit_limit;

`ifdef CC_LIMIT_EN
  localparam logic [WIDTH-1:0] LIMIT_M1 = WIDTH'(CYCLE_LIMIT - 1);
  // The edge that sees cycle_cnt==CYCLE_LIMIT-1 in RUN is the terminating one;
  // its normal increment lands cycle_cnt exactly on CYCLE_LIMIT.
  assign hit_limit = (state_q == S_RUN) && (cycle_q == LIMIT_M1);
`else
  assign hit_limit = 1'b0;
`endif

  // Next-state logic. clear beats everything; in RUN the limit beats stop.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) state_d = S_RUN;
        end
        S_RUN: begin
          if (hit_limit)  state_d = S_DONE;
          else if (stop)  state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (stop)       state_d = S_PAUSE;
          else if (start) state_d = S_RUN;
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Counter and overflow update. Counting depends on the state before the
  // edge, so the increment at a stop edge still happens.
  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    ovf_d     = ovf_q;
    if (clear) begin
      cycle_d   = '0;
      instret_d = '0;
      ovf_d     = 1'b0;
    end else if (state_q == S_RUN) begin
      cycle_d = cycle_q + 1'b1;
      if (cycle_q == ALL_ONES) ovf_d = 1'b1;
      if (retire) begin
        instret_d = instret_q + 1'b1;
        if (instret_q == ALL_ONES) ovf_d = 1'b1;
      end
    end
  end

  // Read mux samples pre-update values; without a request the data holds.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_req) begin
      unique case (rd_sel)
        2'd0:    rd_data_d = cycle_q;
        2'd1:    rd_data_d = instret_q;
        2'd2:    rd_data_d = {{(WIDTH-4){1'b0}}, running, ovf_q, state_q};
        default: rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cycle_q    <= '0;
      instret_q  <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      instret_q  <= instret_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_req;
      rd_data_q  <= rd_data_d;
    end
  end

`ifdef CC_LIMIT_EN
  logic done_q, done_d;

  // Pulse for the single cycle following the RUN->DONE transition.
  assign done_d = (state_q == S_RUN) && (state_d == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= done_d;
  end

  assign done = done_q;
`else
  assign done = 1'b0;
`endif

  assign running  = (state_q == S_RUN);
  assign overflow = ovf_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_cycle_count_ctrl.sv
module tb_cycle_count_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, clear, retire, rd_req;
  logic [1:0]  rd_sel;

  logic        rd_valid, running, overflow, done;
  logic [15:0] rd_data;

  logic        rd_valid4, running4, overflow4, done4;
  logic [3:0]  rd_data4;

  int errs   = 0;
  int checks = 0;

  logic [15:0] d16;
  logic [3:0]  d4;
  logic        pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  cycle_count_ctrl #(.WIDTH(16), .CYCLE_LIMIT(20)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .retire(retire), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .running(running),
    .overflow(overflow), .done(done)
  );

  // Narrow instance sharing all stimulus, used for the wrap behaviour.
  cycle_count_ctrl #(.WIDTH(4), .CYCLE_LIMIT(16)) dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .retire(retire), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rd_valid4), .rd_data(rd_data4), .running(running4),
    .overflow(overflow4), .done(done4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle read; returns data from both instances.
  task automatic rd(input logic [1:0] sel, output logic [15:0] q16, output logic [3:0] q4);
    rd_req = 1'b1;
    rd_sel = sel;
    tick();
    rd_req = 1'b0;
    chk("rd_valid", 32'(rd_valid), 32'd1);
    q16 = rd_data;
    q4  = rd_data4;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; clear = 0; retire = 0; rd_req = 0; rd_sel = 2'd0;
    tick(2);
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_running",  32'(running),  32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data",  32'(rd_data),  32'd0);
    rd(2'd0, d16, d4);
    chk("rst_cycle", 32'(d16), 32'd0);

    // Start, 10 idle edges, stop edge: 11 counting edges
    pulse_start();
    chk("t1_running", 32'(running), 32'd1);
    tick(10);
    pulse_stop();
    chk("t1_running_off", 32'(running), 32'd0);
    rd(2'd0, d16, d4);
    chk("t1_cycle", 32'(d16), 32'd11);
    rd(2'd2, d16, d4);
    chk("t1_status_pause", 32'(d16), 32'h2);
    tick(3);
    rd(2'd0, d16, d4);
    chk("t1_cycle_held", 32'(d16), 32'd11);

    // instret with 5 of 8 retire pulses, retire in PAUSE ignored
    pulse_clear();
    rd(2'd1, d16, d4);
    chk("t2_instret_clr", 32'(d16), 32'd0);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      retire = pat[i];
      tick();
    end
    retire = 1'b0;
    pulse_stop();
    retire = 1'b1;
    tick(3);
    retire = 1'b0;
    rd(2'd1, d16, d4);
    chk("t2_instret", 32'(d16), 32'd5);
    rd(2'd0, d16, d4);
    chk("t2_cycle", 32'(d16), 32'd9);

    // 17 counting edges: 16-bit holds 17, 4-bit wraps to 1 with overflow
    pulse_clear();
    pulse_start();
    tick(16);
    pulse_stop();
    rd(2'd0, d16, d4);
    chk("t3_cycle16", 32'(d16), 32'd17);
    chk("t3_ovf16", 32'(overflow), 32'd0);
`ifndef CC_LIMIT_EN
    chk("t3_cycle4", 32'(d4), 32'd1);
    chk("t3_ovf4", 32'(overflow4), 32'd1);
    rd(2'd2, d16, d4);
    chk("t3_status4", 32'(d4), 32'h6);
    pulse_clear();
    chk("t3_ovf4_clr", 32'(overflow4), 32'd0);
    rd(2'd0, d16, d4);
    chk("t3_cycle4_clr", 32'(d4), 32'd0);
    rd(2'd2, d16, d4);
    chk("t3_status4_clr", 32'(d4), 32'h0);
`endif

    // clear+stop+start in RUN -> IDLE, zero; stop+start in RUN -> PAUSE
    pulse_clear();
    pulse_start();
    tick(3);
    clear = 1'b1; stop = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; stop = 1'b0; start = 1'b0;
    chk("t4_running", 32'(running), 32'd0);
    rd(2'd2, d16, d4);
    chk("t4_status_idle", 32'(d16), 32'h0);
    rd(2'd0, d16, d4);
    chk("t4_cycle_zero", 32'(d16), 32'd0);
    pulse_start();
    tick(2);
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    rd(2'd2, d16, d4);
    chk("t4_status_pause", 32'(d16), 32'h2);
    rd(2'd0, d16, d4);
    chk("t4_cycle", 32'(d16), 32'd3);

    // Read port latency, hold, read-during-clear, reserved select
    pulse_clear();
    pulse_start();
    tick(7);
    rd_req = 1'b1; rd_sel = 2'd0;
    tick();
    rd_req = 1'b0;
    chk("t5_rd_valid", 32'(rd_valid), 32'd1);
    chk("t5_rd_data", 32'(rd_data), 32'd7);
    tick();
    chk("t5_rd_valid_low", 32'(rd_valid), 32'd0);
    chk("t5_rd_data_hold", 32'(rd_data), 32'd7);
    rd(2'd2, d16, d4);
    chk("t5_status_run", 32'(d16), 32'h9);
    rd_req = 1'b1; rd_sel = 2'd0; clear = 1'b1;
    tick();
    rd_req = 1'b0; clear = 1'b0;
    chk("t5_rd_preclear", 32'(rd_data), 32'd10);
    rd(2'd0, d16, d4);
    chk("t5_cycle_cleared", 32'(d16), 32'd0);
    rd(2'd3, d16, d4);
    chk("t5_reserved", 32'(d16), 32'd0);

    // Asynchronous reset mid-run
    pulse_start();
    tick(8);
    rd(2'd0, d16, d4);
    chk("t6_cycle_before_rst", 32'(d16), 32'd8);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_running",  32'(running),  32'd0);
    chk("t6_async_rd_valid", 32'(rd_valid), 32'd0);
    chk("t6_async_rd_data",  32'(rd_data),  32'd0);
    chk("t6_async_overflow", 32'(overflow), 32'd0);
    chk("t6_async_done",     32'(done),     32'd0);
    tick();
    rst = 1'b0;
    tick();
    rd(2'd0, d16, d4);
    chk("t6_cycle_after_rst", 32'(d16), 32'd0);
    rd(2'd2, d16, d4);
    chk("t6_status_after_rst", 32'(d16), 32'h0);

`ifdef CC_LIMIT_EN
    // Limit at 20: terminating edge is the 20th counting edge
    pulse_start();
    tick(19);
    chk("t7_running_pre", 32'(running), 32'd1);
    chk("t7_done_pre", 32'(done), 32'd0);
    tick();
    chk("t7_done_pulse", 32'(done), 32'd1);
    chk("t7_running_done", 32'(running), 32'd0);
    tick();
    chk("t7_done_drop", 32'(done), 32'd0);
    rd(2'd0, d16, d4);
    chk("t7_cycle_limit", 32'(d16), 32'd20);
    pulse_start();
    rd(2'd2, d16, d4);
    chk("t7_status_done", 32'(d16), 32'h3);
    // stop on the terminating edge loses to the limit
    pulse_clear();
    pulse_start();
    tick(19);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t7_stop_vs_limit_done", 32'(done), 32'd1);
    rd(2'd2, d16, d4);
    chk("t7_stop_vs_limit_state", 32'(d16), 32'h3);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
